// File: rtl/hs4_tx_if.sv
// Handshake bundle for hs4_tx: synchronous valid/ready source side plus the
// 4-phase bundled-data side toward the first asynchronous stage.
// slave  : transmitter view (accepts source words, drives r_o/d_o).
// master : environment view (drives source words and the async acknowledge).
interface hs4_tx_if #(
  parameter int unsigned N = 1
);
  logic         valid_i;
  logic         ready_i;
  logic [N-1:0] data_i;
  logic         r_o;
  logic         a_o;
  logic [N-1:0] d_o;

  modport slave (
    input  valid_i,
    input  data_i,
    input  a_o,
    output ready_i,
    output r_o,
    output d_o
  );

  modport master (
    output valid_i,
    output data_i,
    output a_o,
    input  ready_i,
    input  r_o,
    input  d_o
  );
endinterface

// File: rtl/hs4_tx.sv
// hs4_tx: clocked initiator of a 4-phase bundled-data handshake.
// Words from a valid/ready source are buffered in a small FIFO and sent one per
// full return-to-zero cycle on r_o/a_o. a_o is asynchronous and synchronized.
// Optional feature: define HS4_TX_TIMEOUT_EN to enable the sticky ack watchdog
// on err_o; otherwise err_o is tied low.
module hs4_tx #(
  parameter int unsigned N            = 1,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter logic [N-1:0] RdataVal    = '0,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  hs4_tx_if.slave                      bus,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         err_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned SetupW = $clog2(SETUP_CYCLES + 1);

  localparam logic [CntW-1:0]   CntFull   = CntW'(DEPTH);
  localparam logic [SetupW-1:0] SetupLast = SetupW'(SETUP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StReq, StRtz} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic                r_req;
  logic [N-1:0]        r_data;
  logic [N-1:0]        r_mem [DEPTH];
  logic [PtrW-1:0]     r_wptr;
  logic [PtrW-1:0]     r_rptr;
  logic [CntW-1:0]     r_count;
  logic [SetupW-1:0]   r_setup_cnt;
  logic [SYNC_STAGES-1:0] r_sync;

  logic w_a_s;
  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_nonempty;

  assign w_a_s      = r_sync[SYNC_STAGES-1];
  assign w_nonempty = (r_count != '0);
  // Readiness comes from registered occupancy only; held low during reset.
  assign w_ready    = !rst && (r_count < CntFull);
  assign w_push     = bus.valid_i && w_ready;

  assign bus.ready_i = w_ready;
  assign bus.r_o     = r_req;
  assign bus.d_o     = r_data;
  assign count_o     = r_count;

  // Synchronize the asynchronous acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.a_o};
    end
  end

  // FIFO storage; contents need no reset, pointers and count guard validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.data_i;
    end
  end

  // FIFO pointers and occupancy; push and pop on one edge cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // State register; r_o is registered from the next state so it is a clean flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_req   <= (w_state_d == StReq);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_nonempty) w_state_d = StSetup;
      StSetup: if (r_setup_cnt == SetupLast) w_state_d = StReq;
      StReq:   if (w_a_s) w_state_d = StRtz;
      StRtz: begin
        if (!w_a_s) w_state_d = w_nonempty ? StSetup : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output decode: when to pop the FIFO head into d_o.
  always_comb begin
    w_pop = 1'b0;
    unique case (r_state)
      StIdle:  w_pop = w_nonempty;
      StRtz:   w_pop = !w_a_s && w_nonempty;
      default: w_pop = 1'b0;
    endcase
  end

  // Bundled data and setup (bundling delay) counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= RdataVal;
      r_setup_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_data      <= r_mem[r_rptr];
        r_setup_cnt <= '0;
      end else if (r_state == StSetup) begin
        r_setup_cnt <= r_setup_cnt + 1'b1;
      end
    end
  end

`ifdef HS4_TX_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT);

  logic [ToW-1:0] r_to_cnt;
  logic [ToW-1:0] w_to_cnt_d;
  logic           r_err;

  // Watchdog count: restarts on every state change, saturates at the limit.
  always_comb begin
    w_to_cnt_d = r_to_cnt;
    if (w_state_d != r_state) begin
      w_to_cnt_d = '0;
    end else if ((r_state == StReq || r_state == StRtz) && r_to_cnt != ToMax) begin
      w_to_cnt_d = r_to_cnt + 1'b1;
    end
  end

  // Sticky error set on the edge the count reaches the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= w_to_cnt_d;
      if (w_to_cnt_d == ToMax) r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule
